// File: rtl/mem_channel_arbiter_pkg.sv
// Shared types and bus widths for the cache/memory read arbiter.
package mem_channel_arbiter_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_ID_W   = 4;
  localparam int AXI_LEN_W  = 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } ArbState;

  typedef enum logic {
    REQ_IC = 1'b0,
    REQ_DC = 1'b1
  } MemRequester;

endpackage

// File: rtl/mem_channel_arbiter_if.sv
// AXI channel interfaces; ARLEN/AWLEN carry the beat count, not beats minus one.
interface axi_read_address;
  import mem_channel_arbiter_pkg::*;
  logic [AXI_ADDR_W-1:0] araddr;
  logic [AXI_LEN_W-1:0]  arlen;
  logic [AXI_ID_W-1:0]   arid;
  logic                  arvalid;
  logic                  arready;
  modport master (output araddr, arlen, arid, arvalid, input arready);
  modport slave  (input araddr, arlen, arid, arvalid, output arready);
endinterface

interface axi_read_data;
  import mem_channel_arbiter_pkg::*;
  logic [AXI_DATA_W-1:0] rdata;
  logic [AXI_ID_W-1:0]   rid;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;
  modport master (input rdata, rid, rlast, rvalid, output rready);
  modport slave  (output rdata, rid, rlast, rvalid, input rready);
endinterface

interface axi_write_address;
  import mem_channel_arbiter_pkg::*;
  logic [AXI_ADDR_W-1:0] awaddr;
  logic [AXI_LEN_W-1:0]  awlen;
  logic [AXI_ID_W-1:0]   awid;
  logic                  awvalid;
  logic                  awready;
  modport master (output awaddr, awlen, awid, awvalid, input awready);
  modport slave  (input awaddr, awlen, awid, awvalid, output awready);
endinterface

interface axi_write_data;
  import mem_channel_arbiter_pkg::*;
  logic [AXI_DATA_W-1:0]   wdata;
  logic [AXI_DATA_W/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  modport master (output wdata, wstrb, wlast, wvalid, input wready);
  modport slave  (input wdata, wstrb, wlast, wvalid, output wready);
endinterface

interface axi_write_response;
  import mem_channel_arbiter_pkg::*;
  logic [AXI_ID_W-1:0] bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  modport master (input bid, bresp, bvalid, output bready);
  modport slave  (output bid, bresp, bvalid, input bready);
endinterface

// File: rtl/mem_channel_arbiter_arb_rr2.sv
// Two-way round-robin pick: a lone eligible requester wins, a tie goes to i_priority.
module arb_rr2 (
  input  logic [1:0] i_eligible,
  input  logic       i_priority,
  output logic       o_grant
);

  // Grant index selection
  always_comb begin
    o_grant = i_priority;
    case (i_eligible)
      2'b01:   o_grant = 1'b0;
      2'b10:   o_grant = 1'b1;
      2'b11:   o_grant = i_priority;
      default: o_grant = i_priority;
    endcase
  end

endmodule

// File: rtl/mem_channel_arbiter.sv
// Shares one AXI memory port between I-cache and D-cache: one read burst at a time,
// round-robin between requesters, D-cache writes passed straight through.
module mem_channel_arbiter
  import mem_channel_arbiter_pkg::*;
#(
  parameter int MAX_BEATS  = 16,
  parameter int FIRST_PRIO = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  axi_read_address.slave          ic_read_address,
  axi_read_data.slave             ic_read_data,
  axi_read_address.slave          dc_read_address,
  axi_read_data.slave             dc_read_data,
  axi_write_address.slave         dc_write_address,
  axi_write_data.slave            dc_write_data,
  axi_write_response.slave        dc_write_response,
  axi_read_address.master         mem_read_address,
  axi_read_data.master            mem_read_data,
  axi_write_address.master        mem_write_address,
  axi_write_data.master           mem_write_data,
  axi_write_response.master       mem_write_response,
  output logic                    proto_err
);

  localparam int CNT_W = $clog2(MAX_BEATS) + 1;
  localparam logic [1:0] S_IDLE = ARB_IDLE;
  localparam logic [1:0] S_ADDR = ARB_ADDR;
  localparam logic [1:0] S_DATA = ARB_DATA;

  logic [1:0]       r_state;
  MemRequester      r_owner;
  logic             r_prio;
  logic             r_wr_pending;
  logic             r_proto_err;
  logic [CNT_W-1:0] r_beat_cnt;

  logic [1:0]           w_elig;
  logic                 w_grant;
  logic                 w_mem_arvalid;
  logic                 w_ic_arready;
  logic                 w_dc_arready;
  logic                 w_ic_rvalid;
  logic                 w_dc_rvalid;
  logic                 w_mem_rready;
  logic [AXI_LEN_W-1:0] w_sel_arlen;
  logic [CNT_W-1:0]     w_len_clamped;
  logic                 w_ar_hs;
  logic                 w_beat;
  logic                 w_cnt_last;
  logic                 w_burst_end;
  logic                 w_dc_awready;
  logic                 w_aw_hs;
  logic                 w_b_hs;

  // A D-cache read must not overtake its own outstanding write
  assign w_elig = {dc_read_address.arvalid & ~r_wr_pending, ic_read_address.arvalid};

  arb_rr2 u_rr2 (
    .i_eligible (w_elig),
    .i_priority (r_prio),
    .o_grant    (w_grant)
  );

  // Read-channel valid/ready steering by FSM state and owner
  always_comb begin
    w_mem_arvalid = 1'b0;
    w_ic_arready  = 1'b0;
    w_dc_arready  = 1'b0;
    w_ic_rvalid   = 1'b0;
    w_dc_rvalid   = 1'b0;
    w_mem_rready  = 1'b0;
    case (r_state)
      S_ADDR: begin
        w_mem_arvalid = 1'b1;
        if (r_owner == REQ_DC) begin
          w_dc_arready = mem_read_address.arready;
        end else begin
          w_ic_arready = mem_read_address.arready;
        end
      end
      S_DATA: begin
        if (r_owner == REQ_DC) begin
          w_dc_rvalid  = mem_read_data.rvalid;
          w_mem_rready = dc_read_data.rready;
        end else begin
          w_ic_rvalid  = mem_read_data.rvalid;
          w_mem_rready = ic_read_data.rready;
        end
      end
      default: begin
        w_mem_arvalid = 1'b0;
      end
    endcase
  end

  assign w_sel_arlen = (r_owner == REQ_DC) ? dc_read_address.arlen : ic_read_address.arlen;

  // Burst length clamp: zero means one beat, oversize bursts saturate
  always_comb begin
    if (w_sel_arlen == {AXI_LEN_W{1'b0}}) begin
      w_len_clamped = CNT_W'(1);
    end else if (w_sel_arlen > AXI_LEN_W'(MAX_BEATS)) begin
      w_len_clamped = CNT_W'(MAX_BEATS);
    end else begin
      w_len_clamped = w_sel_arlen[CNT_W-1:0];
    end
  end

  assign w_ar_hs     = w_mem_arvalid & mem_read_address.arready;
  assign w_beat      = w_mem_rready & mem_read_data.rvalid;
  assign w_cnt_last  = (r_beat_cnt == CNT_W'(1));
  assign w_burst_end = w_cnt_last | mem_read_data.rlast;

  assign mem_read_address.arvalid = w_mem_arvalid;
  assign mem_read_address.araddr  = (r_owner == REQ_DC) ? dc_read_address.araddr : ic_read_address.araddr;
  assign mem_read_address.arid    = (r_owner == REQ_DC) ? dc_read_address.arid : ic_read_address.arid;
  assign mem_read_address.arlen   = w_sel_arlen;
  assign ic_read_address.arready  = w_ic_arready;
  assign dc_read_address.arready  = w_dc_arready;

  assign mem_read_data.rready = w_mem_rready;
  assign ic_read_data.rvalid  = w_ic_rvalid;
  assign dc_read_data.rvalid  = w_dc_rvalid;
  assign ic_read_data.rdata   = mem_read_data.rdata;
  assign ic_read_data.rid     = mem_read_data.rid;
  assign ic_read_data.rlast   = mem_read_data.rlast;
  assign dc_read_data.rdata   = mem_read_data.rdata;
  assign dc_read_data.rid     = mem_read_data.rid;
  assign dc_read_data.rlast   = mem_read_data.rlast;

  // Read FSM, beat counter, priority pointer and sticky length-mismatch flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_owner     <= REQ_IC;
      r_prio      <= 1'(FIRST_PRIO);
      r_beat_cnt  <= {CNT_W{1'b0}};
      r_proto_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|w_elig) begin
            r_owner <= MemRequester'(w_grant);
            r_state <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (w_ar_hs) begin
            r_beat_cnt <= w_len_clamped;
            r_state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_beat) begin
            r_beat_cnt <= r_beat_cnt - CNT_W'(1);
            if (w_burst_end) begin
              r_state <= S_IDLE;
              r_prio  <= ~r_owner;
              if (w_cnt_last != mem_read_data.rlast) begin
                r_proto_err <= 1'b1;
              end
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign proto_err = r_proto_err;

  // Only one write may be in flight so a later read cannot pass it
  assign w_dc_awready = mem_write_address.awready & ~r_wr_pending;
  assign w_aw_hs      = dc_write_address.awvalid & w_dc_awready;
  assign w_b_hs       = mem_write_response.bvalid & dc_write_response.bready;

  // Outstanding-write tracker; a new AW wins over a coincident B
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_pending <= 1'b0;
    end else if (w_aw_hs) begin
      r_wr_pending <= 1'b1;
    end else if (w_b_hs) begin
      r_wr_pending <= 1'b0;
    end
  end

  assign mem_write_address.awaddr  = dc_write_address.awaddr;
  assign mem_write_address.awlen   = dc_write_address.awlen;
  assign mem_write_address.awid    = dc_write_address.awid;
  assign mem_write_address.awvalid = dc_write_address.awvalid;
  assign dc_write_address.awready  = w_dc_awready;

  assign mem_write_data.wdata  = dc_write_data.wdata;
  assign mem_write_data.wstrb  = dc_write_data.wstrb;
  assign mem_write_data.wlast  = dc_write_data.wlast;
  assign mem_write_data.wvalid = dc_write_data.wvalid;
  assign dc_write_data.wready  = mem_write_data.wready;

  assign dc_write_response.bid    = mem_write_response.bid;
  assign dc_write_response.bresp  = mem_write_response.bresp;
  assign dc_write_response.bvalid = mem_write_response.bvalid;
  assign mem_write_response.bready = dc_write_response.bready;

endmodule

// File: tb/tb_mem_channel_arbiter.sv
// Directed bench for mem_channel_arbiter: grant order, write hold-off, length checks, reset.
module tb_mem_channel_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic proto_err;
  int   n_checks = 0;
  int   n_errs   = 0;

  axi_read_address   ic_ra ();
  axi_read_data      ic_rd ();
  axi_read_address   dc_ra ();
  axi_read_data      dc_rd ();
  axi_write_address  dc_wa ();
  axi_write_data     dc_wd ();
  axi_write_response dc_wb ();
  axi_read_address   mem_ra ();
  axi_read_data      mem_rd ();
  axi_write_address  mem_wa ();
  axi_write_data     mem_wd ();
  axi_write_response mem_wb ();

  mem_channel_arbiter #(.MAX_BEATS(16), .FIRST_PRIO(1)) dut (
    .clk                (clk),
    .rst                (rst),
    .ic_read_address    (ic_ra),
    .ic_read_data       (ic_rd),
    .dc_read_address    (dc_ra),
    .dc_read_data       (dc_rd),
    .dc_write_address   (dc_wa),
    .dc_write_data      (dc_wd),
    .dc_write_response  (dc_wb),
    .mem_read_address   (mem_ra),
    .mem_read_data      (mem_rd),
    .mem_write_address  (mem_wa),
    .mem_write_data     (mem_wd),
    .mem_write_response (mem_wb),
    .proto_err          (proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ic_ra.araddr = 32'h0; ic_ra.arlen = 8'd0; ic_ra.arid = 4'd0; ic_ra.arvalid = 1'b0;
    dc_ra.araddr = 32'h0; dc_ra.arlen = 8'd0; dc_ra.arid = 4'd0; dc_ra.arvalid = 1'b0;
    ic_rd.rready = 1'b0; dc_rd.rready = 1'b0;
    dc_wa.awaddr = 32'h0; dc_wa.awlen = 8'd0; dc_wa.awid = 4'd0; dc_wa.awvalid = 1'b0;
    dc_wd.wdata = 32'h0; dc_wd.wstrb = 4'h0; dc_wd.wlast = 1'b0; dc_wd.wvalid = 1'b0;
    dc_wb.bready = 1'b0;
    mem_ra.arready = 1'b0;
    mem_rd.rdata = 32'h0; mem_rd.rid = 4'd0; mem_rd.rlast = 1'b0; mem_rd.rvalid = 1'b0;
    mem_wa.awready = 1'b0; mem_wd.wready = 1'b0;
    mem_wb.bid = 4'd0; mem_wb.bresp = 2'd0; mem_wb.bvalid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One isolated burst from an idle arbiter; last_at = 0 means RLAST never asserted
  task automatic burst(input logic side_dc, input logic [31:0] addr, input logic [7:0] len,
                       input int nbeats, input int last_at);
    if (side_dc) begin
      dc_ra.arvalid = 1'b1; dc_ra.araddr = addr; dc_ra.arlen = len;
    end else begin
      ic_ra.arvalid = 1'b1; ic_ra.araddr = addr; ic_ra.arlen = len;
    end
    nxt();
    mem_ra.arready = 1'b1;
    #1;
    chk("bu_araddr", mem_ra.araddr, addr);
    nxt();
    ic_ra.arvalid = 1'b0; dc_ra.arvalid = 1'b0; mem_ra.arready = 1'b0;
    ic_rd.rready = 1'b1; dc_rd.rready = 1'b1;
    for (int b = 0; b < nbeats; b++) begin
      mem_rd.rvalid = 1'b1;
      mem_rd.rdata  = 32'h1000 + 32'(b);
      mem_rd.rlast  = (b == last_at - 1);
      #1;
      chk("bu_owner_rvalid", side_dc ? dc_rd.rvalid : ic_rd.rvalid, 1'b1);
      nxt();
    end
    mem_rd.rlast = 1'b0;
    #1;
    chk("bu_ended", side_dc ? dc_rd.rvalid : ic_rd.rvalid, 1'b0);
    mem_rd.rvalid = 1'b0;
  endtask

  initial begin
    clear_inputs();
    do_reset();

    // reset values
    mem_wa.awready = 1'b1;
    #1;
    chk("rst_mem_arvalid", mem_ra.arvalid, 1'b0);
    chk("rst_ic_arready", ic_ra.arready, 1'b0);
    chk("rst_dc_arready", dc_ra.arready, 1'b0);
    chk("rst_ic_rvalid", ic_rd.rvalid, 1'b0);
    chk("rst_dc_rvalid", dc_rd.rvalid, 1'b0);
    chk("rst_mem_rready", mem_rd.rready, 1'b0);
    chk("rst_proto_err", proto_err, 1'b0);
    chk("rst_dc_awready", dc_wa.awready, 1'b1);
    mem_wa.awready = 1'b0;

    // ic-only 4-beat burst
    nxt();
    ic_ra.arvalid = 1'b1; ic_ra.araddr = 32'h100; ic_ra.arlen = 8'd4; ic_ra.arid = 4'd3;
    mem_ra.arready = 1'b1;
    #1;
    chk("t1_idle_mem_arvalid", mem_ra.arvalid, 1'b0);
    chk("t1_idle_ic_arready", ic_ra.arready, 1'b0);
    nxt();
    #1;
    chk("t1_mem_arvalid", mem_ra.arvalid, 1'b1);
    chk("t1_araddr", mem_ra.araddr, 32'h100);
    chk("t1_arlen", mem_ra.arlen, 32'd4);
    chk("t1_arid", mem_ra.arid, 32'd3);
    chk("t1_ic_arready", ic_ra.arready, 1'b1);
    chk("t1_dc_arready", dc_ra.arready, 1'b0);
    nxt();
    ic_ra.arvalid = 1'b0; mem_ra.arready = 1'b0;
    ic_rd.rready = 1'b0; dc_rd.rready = 1'b1;
    mem_rd.rvalid = 1'b1; mem_rd.rdata = 32'hA0;
    #1;
    chk("t1_rready_follows_owner", mem_rd.rready, 1'b0);
    chk("t1_rvalid_stalled", ic_rd.rvalid, 1'b1);
    nxt();
    ic_rd.rready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      mem_rd.rvalid = 1'b1;
      mem_rd.rdata  = 32'hA0 + 32'(b);
      mem_rd.rlast  = (b == 3);
      #1;
      chk("t1_ic_rvalid", ic_rd.rvalid, 1'b1);
      chk("t1_dc_rvalid", dc_rd.rvalid, 1'b0);
      chk("t1_ic_rdata", ic_rd.rdata, 32'hA0 + 32'(b));
      chk("t1_dc_rdata_bcast", dc_rd.rdata, 32'hA0 + 32'(b));
      nxt();
    end
    mem_rd.rlast = 1'b0;
    #1;
    chk("t1_after_ic_rvalid", ic_rd.rvalid, 1'b0);
    chk("t1_after_mem_rready", mem_rd.rready, 1'b0);
    chk("t1_after_mem_arvalid", mem_ra.arvalid, 1'b0);
    mem_rd.rvalid = 1'b0;

    // simultaneous requests after reset: dc first, then round-robin
    do_reset();
    ic_ra.arvalid = 1'b1; ic_ra.araddr = 32'h200; ic_ra.arlen = 8'd1;
    dc_ra.arvalid = 1'b1; dc_ra.araddr = 32'h300; dc_ra.arlen = 8'd2; dc_ra.arid = 4'd5;
    mem_ra.arready = 1'b1;
    nxt();
    #1;
    chk("t2_first_araddr", mem_ra.araddr, 32'h300);
    chk("t2_first_arid", mem_ra.arid, 32'd5);
    chk("t2_dc_arready", dc_ra.arready, 1'b1);
    chk("t2_ic_arready", ic_ra.arready, 1'b0);
    nxt();
    dc_ra.arvalid = 1'b0; mem_ra.arready = 1'b0;
    ic_rd.rready = 1'b1; dc_rd.rready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      mem_rd.rvalid = 1'b1;
      mem_rd.rlast  = (b == 1);
      #1;
      chk("t2_dc_rvalid", dc_rd.rvalid, 1'b1);
      chk("t2_ic_rvalid", ic_rd.rvalid, 1'b0);
      nxt();
    end
    mem_rd.rvalid = 1'b0; mem_rd.rlast = 1'b0;
    dc_ra.arvalid = 1'b1; dc_ra.araddr = 32'h304; dc_ra.arlen = 8'd1;
    #1;
    chk("t2_turnaround_idle", mem_ra.arvalid, 1'b0);
    nxt();
    mem_ra.arready = 1'b1;
    #1;
    chk("t2_second_arvalid", mem_ra.arvalid, 1'b1);
    chk("t2_second_araddr_ic", mem_ra.araddr, 32'h200);
    chk("t2_second_ic_arready", ic_ra.arready, 1'b1);
    nxt();
    ic_ra.arvalid = 1'b0; mem_ra.arready = 1'b0;
    mem_rd.rvalid = 1'b1; mem_rd.rlast = 1'b1;
    #1;
    chk("t2_second_ic_rvalid", ic_rd.rvalid, 1'b1);
    nxt();
    mem_rd.rvalid = 1'b0; mem_rd.rlast = 1'b0;
    nxt();
    mem_ra.arready = 1'b1;
    #1;
    chk("t2_third_araddr_dc", mem_ra.araddr, 32'h304);
    nxt();
    dc_ra.arvalid = 1'b0; mem_ra.arready = 1'b0;
    mem_rd.rvalid = 1'b1; mem_rd.rlast = 1'b1;
    #1;
    chk("t2_third_dc_rvalid", dc_rd.rvalid, 1'b1);
    nxt();
    mem_rd.rvalid = 1'b0; mem_rd.rlast = 1'b0;

    // write pass-through and dc read held off by an outstanding write
    dc_wa.awvalid = 1'b1; dc_wa.awaddr = 32'h400; dc_wa.awlen = 8'd1; dc_wa.awid = 4'd2;
    mem_wa.awready = 1'b1;
    dc_wd.wvalid = 1'b1; dc_wd.wdata = 32'h55; dc_wd.wstrb = 4'hF; dc_wd.wlast = 1'b1;
    mem_wd.wready = 1'b1;
    #1;
    chk("t3_mem_awvalid", mem_wa.awvalid, 1'b1);
    chk("t3_mem_awaddr", mem_wa.awaddr, 32'h400);
    chk("t3_dc_awready", dc_wa.awready, 1'b1);
    chk("t3_mem_wdata", mem_wd.wdata, 32'h55);
    chk("t3_dc_wready", dc_wd.wready, 1'b1);
    nxt();
    dc_wa.awvalid = 1'b0; dc_wd.wvalid = 1'b0;
    dc_ra.arvalid = 1'b1; dc_ra.araddr = 32'h500; dc_ra.arlen = 8'd1;
    ic_ra.arvalid = 1'b1; ic_ra.araddr = 32'h600; ic_ra.arlen = 8'd1;
    #1;
    chk("t3_awready_pending", dc_wa.awready, 1'b0);
    nxt();
    mem_ra.arready = 1'b1;
    #1;
    chk("t3_ic_granted", mem_ra.araddr, 32'h600);
    nxt();
    ic_ra.arvalid = 1'b0; mem_ra.arready = 1'b0;
    mem_rd.rvalid = 1'b1; mem_rd.rlast = 1'b1;
    #1;
    chk("t3_ic_rvalid", ic_rd.rvalid, 1'b1);
    nxt();
    mem_rd.rvalid = 1'b0; mem_rd.rlast = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nxt();
      chk("t3_dc_blocked", mem_ra.arvalid, 1'b0);
    end
    nxt();
    mem_wb.bvalid = 1'b1; mem_wb.bid = 4'd2; dc_wb.bready = 1'b1;
    #1;
    chk("t3_dc_bvalid", dc_wb.bvalid, 1'b1);
    chk("t3_dc_bid", dc_wb.bid, 32'd2);
    chk("t3_mem_bready", mem_wb.bready, 1'b1);
    chk("t3_b_cycle_no_grant", mem_ra.arvalid, 1'b0);
    nxt();
    mem_wb.bvalid = 1'b0;
    #1;
    chk("t3_grant_cycle_idle", mem_ra.arvalid, 1'b0);
    chk("t3_awready_freed", dc_wa.awready, 1'b1);
    nxt();
    mem_ra.arready = 1'b1;
    #1;
    chk("t3_dc_arvalid", mem_ra.arvalid, 1'b1);
    chk("t3_dc_araddr", mem_ra.araddr, 32'h500);
    nxt();
    dc_ra.arvalid = 1'b0; mem_ra.arready = 1'b0;
    mem_rd.rvalid = 1'b1; mem_rd.rlast = 1'b1;
    nxt();
    mem_rd.rvalid = 1'b0; mem_rd.rlast = 1'b0;

    // AW and B handshake in the same cycle keeps the write pending
    dc_wa.awvalid = 1'b1; dc_wa.awaddr = 32'h700;
    mem_wb.bvalid = 1'b1;
    #1;
    chk("t4_awready_before", dc_wa.awready, 1'b1);
    nxt();
    dc_wa.awvalid = 1'b0; mem_wb.bvalid = 1'b0;
    #1;
    chk("t4_pending_kept", dc_wa.awready, 1'b0);
    nxt();
    chk("t4_pending_still", dc_wa.awready, 1'b0);
    nxt();
    mem_wb.bvalid = 1'b1;
    #1;
    chk("t4_b_cycle", dc_wa.awready, 1'b0);
    nxt();
    mem_wb.bvalid = 1'b0;
    #1;
    chk("t4_released", dc_wa.awready, 1'b1);

    // burst length edge cases and mismatch detection
    burst(1'b0, 32'h800, 8'd0, 1, 1);
    chk("t5_len0_no_err", proto_err, 1'b0);
    burst(1'b0, 32'hB00, 8'd20, 16, 16);
    chk("t5_clamp_no_err", proto_err, 1'b0);
    burst(1'b1, 32'hB40, 8'd3, 3, 3);
    chk("t5_dc_no_err", proto_err, 1'b0);
    burst(1'b0, 32'hC00, 8'd2, 2, 0);
    chk("t5_no_rlast_err", proto_err, 1'b1);
    do_reset();
    chk("t5_err_cleared", proto_err, 1'b0);
    burst(1'b0, 32'hC40, 8'd4, 2, 2);
    chk("t5_early_rlast_err", proto_err, 1'b1);
    burst(1'b0, 32'hC80, 8'd1, 1, 1);
    chk("t5_err_sticky", proto_err, 1'b1);

    // reset during beat 2 of an 8-beat burst
    do_reset();
    ic_ra.arvalid = 1'b1; ic_ra.araddr = 32'h900; ic_ra.arlen = 8'd8;
    nxt();
    mem_ra.arready = 1'b1;
    nxt();
    ic_ra.arvalid = 1'b0; mem_ra.arready = 1'b0; ic_rd.rready = 1'b1;
    mem_rd.rvalid = 1'b1;
    nxt();
    #1;
    chk("t6_beat2_rvalid", ic_rd.rvalid, 1'b1);
    rst = 1'b1;
    #1;
    chk("t6_rst_ic_rvalid", ic_rd.rvalid, 1'b0);
    chk("t6_rst_mem_rready", mem_rd.rready, 1'b0);
    chk("t6_rst_mem_arvalid", mem_ra.arvalid, 1'b0);
    clear_inputs();
    nxt();
    rst = 1'b0;
    ic_ra.arvalid = 1'b1; ic_ra.araddr = 32'hA00; ic_ra.arlen = 8'd1;
    nxt();
    #1;
    chk("t6_regrant_arvalid", mem_ra.arvalid, 1'b1);
    chk("t6_regrant_araddr", mem_ra.araddr, 32'hA00);
    clear_inputs();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_channel_arbiter.md
# mem_channel_arbiter

Shares the single AXI memory port between the I-cache (read only) and the D-cache (read and write). Read bursts are granted round-robin, one outstanding burst at a time, with R beats routed back to the owner. The D-cache write channel passes through. A D-cache read is held off while any D-cache write response is outstanding. The block sits between both caches and the memory AXI interfaces at the top of mips_core.

## Interface
Parameters:
- MAX_BEATS, 16: largest burst length accepted; sizes the beat counter.
- FIRST_PRIO, 1: requester favoured after reset (0 = I-cache, 1 = D-cache).

Ports (clock and reset first; reset is asynchronous, active-high):
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- ic_read_address  axi_read_address.slave  ifc  I-cache read address
- ic_read_data  axi_read_data.slave  ifc  I-cache read data
- dc_read_address  axi_read_address.slave  ifc  D-cache read address
- dc_read_data  axi_read_data.slave  ifc  D-cache read data
- dc_write_address / dc_write_data / dc_write_response  .slave  ifc  D-cache write channels
- mem_read_address / mem_read_data  .master  ifc  memory read port
- mem_write_address / mem_write_data / mem_write_response  .master  ifc  memory write port
- proto_err  output  1  sticky; set on a burst length mismatch

## Operation
- ARLEN follows the codebase convention: it is the beat count, not beats minus 1.
- Read FSM states are ARB_IDLE, ARB_ADDR and ARB_DATA.
- ARB_IDLE:
  - Both upstream ARREADY are 0 and mem ARVALID is 0.
  - Eligible requesters: ic when its ARVALID is 1; dc when its ARVALID is 1 and wr_pending == 0.
  - One eligible requester is granted. When both are eligible, the priority pointer picks.
  - On a grant, latch owner and go to ARB_ADDR.
- ARB_ADDR:
  - mem ARVALID = 1. ARADDR, ARID and ARLEN come live from the owner.
  - Owner ARREADY = mem ARREADY. The non-owner ARREADY = 0.
  - On the handshake: load beat_cnt = ARLEN (clamped to MAX_BEATS) and go to ARB_DATA.
- ARB_DATA:
  - Owner RVALID = mem RVALID. The non-owner RVALID = 0.
  - RDATA, RID and RLAST are broadcast to both requesters.
  - mem RREADY = owner RREADY.
  - Each accepted beat decrements beat_cnt.
  - The burst ends on the accepted beat where beat_cnt == 1 or RLAST == 1, whichever comes first. If these two disagree, set proto_err.
  - On the end: return to ARB_IDLE and point priority at the non-owner.
- Write path:
  - AW, W and B are combinational pass-through dc↔mem, except that dc AWREADY = mem AWREADY & ~wr_pending.
  - wr_pending: set on an AW handshake, cleared on a B handshake. If both occur in the same cycle, wr_pending stays 1.
  - The read FSM never gates the write path.

## Timing
- Reset values:
  - state = ARB_IDLE, priority = FIRST_PRIO, wr_pending = 0, proto_err = 0, beat_cnt = 0.
  - All mem VALIDs, RREADY and upstream READYs/RVALIDs are 0.
  - The write pass-through reflects live inputs (it resets to the inputs' values).
- Request latency:
  - ARVALID seen in ARB_IDLE in cycle N gives mem ARVALID in cycle N+1.
  - Minimum address handshake is cycle N+1.
  - First beat can be accepted in cycle N+2.
- Turnaround:
  - The cycle after the last beat is ARB_IDLE.
  - The next grant is made in that cycle, so the next mem ARVALID comes 2 cycles after the last beat.
- Write pass-through adds zero latency.
- Requesters must hold ARVALID and ARADDR stable until ARREADY. A deasserted ARVALID in ARB_ADDR is not retracted; it is a requester protocol violation.
- Reset asserted mid-burst: the FSM goes to ARB_IDLE immediately (asynchronously) and the in-flight burst is abandoned. Memory is reset by the same rst.
- beat_cnt is $clog2(MAX_BEATS)+1 bits wide. ARLEN = 0 is treated as 1.

## Structure
- mips_core_pkg gains:
  - typedef enum ArbState {ARB_IDLE, ARB_ADDR, ARB_DATA}
  - typedef enum logic MemRequester {REQ_IC = 0, REQ_DC = 1}
- One sub-module, arb_rr2: a 2-input round-robin pick. Inputs are eligible[1:0] and priority; output is the grant index. It is combinational.
- The FSM, beat counter, wr_pending and proto_err stay in the top module.

## Test plan
- ic only, ARADDR=0x100, ARLEN=4, memory returns 4 beats with RLAST on the 4th -> ic receives 4 beats, dc RVALID stays 0, FSM back in ARB_IDLE the cycle after the 4th beat.
- ic and dc both request in the same cycle after reset (FIRST_PRIO=1) -> dc burst first, then ic. A repeat simultaneous request -> ic first.
- dc AW handshake with B delayed 10 cycles; dc ARVALID raised meanwhile -> ic may still be granted; dc granted only in the cycle after the B handshake.
- AW handshake and B handshake for a previous write in the same cycle -> wr_pending stays 1 and dc AWREADY stays 0 until the next B.
- ARLEN=4 but RLAST on beat 2 -> burst ends after beat 2 and proto_err=1 until reset.
- rst pulsed during beat 2 of an 8-beat burst -> all outputs return to reset values within the same cycle; the next request is granted normally.
